audio_mem_scheduler: RTL and testbench

AUDIO_MEM_SCHEDULER -- requirements
Module: audio_mem_scheduler

---
 rtl/audio_mem_scheduler_pkg.sv | 6 +
 rtl/audio_mem_scheduler_edge_detect.sv | 14 +
 rtl/audio_mem_scheduler.sv | 98 +++++++++
 tb/tb_audio_mem_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mem_scheduler_pkg.sv
// audio_mem_scheduler_pkg: shared state encoding and parameter defaults for the audio memory scheduler
package audio_mem_scheduler_pkg;
  localparam int AMS_ADDR_W  = 10;
  localparam int AMS_GAP_CYC = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_RECORD, ST_PLAY} state_t;
endpackage

// File: rtl/audio_mem_scheduler_edge_detect.sv
// edge_detect: flags a 0->1 transition of a synchronised level against its registered copy
module edge_detect (
  input  logic big_clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic q;
  // previous-cycle copy of the button level
  always_ff @(posedge big_clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= btn;
  assign rise = btn & ~q;
endmodule

// File: rtl/audio_mem_scheduler.sv
// audio_mem_scheduler: arbitrates a shared sample memory between recorder and player with a guard gap
module audio_mem_scheduler
  import audio_mem_scheduler_pkg::*;
#(
  parameter int ADDR_W  = AMS_ADDR_W,
  parameter int GAP_CYC = AMS_GAP_CYC
) (
  input  logic              big_clk,
  input  logic              reset,
  input  logic              record_btn,
  input  logic              play_btn,
  input  logic              rec_done,
  input  logic [3:0]        rec_we,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [31:0]       rec_wdata,
  input  logic [ADDR_W-1:0] play_addr,
  output logic              rec_start,
  output logic              play_start,
  output logic              play_abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] rec_len,
  output logic              rec_valid,
  output logic              busy
);
  localparam int CW = $clog2(GAP_CYC + 1);
  logic rec_edge, play_edge, fresh, gap_done;
  state_t st, nxt, tgt, tgt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  edge_detect u_rec_edge (.big_clk(big_clk), .reset(reset), .btn(record_btn), .rise(rec_edge));
  edge_detect u_play_edge (.big_clk(big_clk), .reset(reset), .btn(play_btn), .rise(play_edge));
  assign gap_done = cnt == CW'(GAP_CYC - 1);
  // state, gap target, gap counter and entry marker
  always_ff @(posedge big_clk or negedge reset)
    if (!reset) begin
      st    <= ST_IDLE;
      tgt   <= ST_RECORD;
      cnt   <= '0;
      fresh <= 1'b0;
    end else begin
      st    <= nxt;
      tgt   <= tgt_nxt;
      cnt   <= cnt_nxt;
      fresh <= nxt != st;
    end
  // next-state selection; record requests always win over play requests
  always_comb begin
    nxt     = st;
    tgt_nxt = tgt;
    cnt_nxt = cnt;
    case (st)
      ST_IDLE:
        if (rec_edge || (play_edge && rec_valid)) begin
          nxt     = ST_GAP;
          tgt_nxt = rec_edge ? ST_RECORD : ST_PLAY;
          cnt_nxt = '0;
        end
      ST_GAP:
        if (rec_edge && tgt == ST_PLAY) begin
          tgt_nxt = ST_RECORD;
          cnt_nxt = '0;
        end else if (gap_done) nxt = tgt;
        else cnt_nxt = cnt + 1'b1;
      ST_RECORD:
        if (rec_done) nxt = ST_IDLE;
      ST_PLAY:
        if (rec_edge) begin
          nxt     = ST_GAP;
          tgt_nxt = ST_RECORD;
          cnt_nxt = '0;
        end else if (play_addr == rec_len) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end
  // recording extent: cleared on entry to RECORD, grown by every write
  always_ff @(posedge big_clk or negedge reset)
    if (!reset) begin
      rec_len   <= '0;
      rec_valid <= 1'b0;
    end else if (st == ST_GAP && nxt == ST_RECORD) begin
      rec_len   <= '0;
      rec_valid <= 1'b0;
    end else if (st == ST_RECORD && rec_we != 4'h0) begin
      rec_valid <= 1'b1;
      if (rec_addr > rec_len) rec_len <= rec_addr;
    end
  // pulses and memory mux decoded from the current state
  always_comb begin
    busy       = st != ST_IDLE;
    rec_start  = st == ST_RECORD && fresh;
    play_start = st == ST_PLAY && fresh;
    play_abort = st == ST_PLAY && (rec_edge || play_addr == rec_len);
    mem_addr   = st == ST_RECORD ? rec_addr : st == ST_PLAY ? play_addr : '0;
    mem_we     = st == ST_RECORD ? rec_we : 4'h0;
    mem_wdata  = st == ST_RECORD ? rec_wdata : 32'h0;
  end
endmodule

// File: tb/tb_audio_mem_scheduler.sv
// tb_audio_mem_scheduler: vector table, directed corner sequences and random traffic against a reference model
module tb_audio_mem_scheduler;
  localparam int AW  = 10;
  localparam int GAP = 2;
  logic big_clk = 0, reset = 0;
  logic record_btn = 0, play_btn = 0, rec_done = 0;
  logic [3:0] rec_we = 0;
  logic [AW-1:0] rec_addr = 0, play_addr = 0;
  logic [31:0] rec_wdata = 0;
  logic rec_start, play_start, play_abort, rec_valid, busy;
  logic [AW-1:0] mem_addr, rec_len;
  logic [3:0] mem_we;
  logic [31:0] mem_wdata;
  int checks = 0, errors = 0;
  int m_mode, m_goal, m_left, m_len;
  bit m_new, m_valid, m_pr, m_pp;
  typedef struct {
    bit rb, pb, dn;
    logic [3:0] we;
    bit busy, rs, ps;
    logic [3:0] mwe;
  } vec_t;
  vec_t tv[14];

  audio_mem_scheduler #(.ADDR_W(AW), .GAP_CYC(GAP)) dut (
    .big_clk(big_clk), .reset(reset), .record_btn(record_btn), .play_btn(play_btn),
    .rec_done(rec_done), .rec_we(rec_we), .rec_addr(rec_addr), .rec_wdata(rec_wdata),
    .play_addr(play_addr), .rec_start(rec_start), .play_start(play_start),
    .play_abort(play_abort), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .rec_len(rec_len), .rec_valid(rec_valid), .busy(busy)
  );

  always #5 big_clk = ~big_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic mreset();
    m_mode = 0; m_goal = 2; m_left = 0; m_len = 0;
    m_new = 0; m_valid = 0; m_pr = 0; m_pp = 0;
  endtask

  // mode: 0 idle, 1 gap, 2 record, 3 play
  task automatic check_model();
    bit re;
    re = record_btn & ~m_pr;
    chk("busy", busy, m_mode != 0);
    chk("rec_start", rec_start, m_mode == 2 && m_new);
    chk("play_start", play_start, m_mode == 3 && m_new);
    chk("play_abort", play_abort, m_mode == 3 && (re || int'(play_addr) == m_len));
    chk("mem_addr", mem_addr, m_mode == 2 ? rec_addr : m_mode == 3 ? play_addr : 0);
    chk("mem_we", mem_we, m_mode == 2 ? rec_we : 0);
    chk("mem_wdata", mem_wdata, m_mode == 2 ? rec_wdata : 0);
    chk("rec_len", rec_len, m_len);
    chk("rec_valid", rec_valid, m_valid);
  endtask

  task automatic model_update();
    bit re, pe;
    re = record_btn & ~m_pr;
    pe = play_btn & ~m_pp;
    m_pr = record_btn;
    m_pp = play_btn;
    m_new = 0;
    if (!reset) mreset();
    else case (m_mode)
      0: if (re) begin m_mode = 1; m_goal = 2; m_left = GAP; end
         else if (pe && m_valid) begin m_mode = 1; m_goal = 3; m_left = GAP; end
      1: if (re && m_goal == 3) begin m_goal = 2; m_left = GAP; end
         else begin
           m_left--;
           if (m_left == 0) begin
             m_mode = m_goal;
             m_new = 1;
             if (m_goal == 2) begin m_len = 0; m_valid = 0; end
           end
         end
      2: begin
           if (rec_we != 0) begin
             m_valid = 1;
             if (int'(rec_addr) > m_len) m_len = int'(rec_addr);
           end
           if (rec_done) m_mode = 0;
         end
      default: if (re) begin m_mode = 1; m_goal = 2; m_left = GAP; end
               else if (int'(play_addr) == m_len) m_mode = 0;
    endcase
  endtask

  task automatic cyc();
    @(negedge big_clk);
    check_model();
    @(posedge big_clk);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    record_btn = 0; play_btn = 0; rec_done = 0; rec_we = 0;
  endtask

  task automatic start_record();
    record_btn = 1;
    cyc();
    repeat (GAP) begin
      #1 chk("gap_no_we", mem_we, 0);
      cyc();
    end
    record_btn = 0;
    #1 chk("rec_start_after_gap", rec_start, 1);
  endtask

  initial begin
    tv = '{
      '{0,1,0,4'h0, 0,0,0,4'h0}, '{0,0,0,4'h0, 0,0,0,4'h0},
      '{1,0,0,4'h0, 0,0,0,4'h0}, '{1,0,0,4'hF, 1,0,0,4'h0},
      '{1,0,0,4'hF, 1,0,0,4'h0}, '{1,0,0,4'hF, 1,1,0,4'hF},
      '{0,1,0,4'h3, 1,0,0,4'h3}, '{0,0,1,4'h0, 1,0,0,4'h0},
      '{0,0,0,4'h0, 0,0,0,4'h0}, '{0,1,0,4'h0, 0,0,0,4'h0},
      '{0,1,0,4'h0, 1,0,0,4'h0}, '{0,0,0,4'h0, 1,0,0,4'h0},
      '{0,0,0,4'h0, 1,0,1,4'h0}, '{0,0,0,4'h0, 1,0,0,4'h0}
    };
    mreset();
    repeat (2) cyc();
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_rec_valid", rec_valid, 0);
    reset = 1;
    cyc();
    rec_addr = 5; rec_wdata = 32'h1234_5678; play_addr = 0;
    for (int i = 0; i < 14; i++) begin
      record_btn = tv[i].rb; play_btn = tv[i].pb; rec_done = tv[i].dn; rec_we = tv[i].we;
      #1;
      chk("tv_busy", busy, tv[i].busy);
      chk("tv_rec_start", rec_start, tv[i].rs);
      chk("tv_play_start", play_start, tv[i].ps);
      chk("tv_mem_we", mem_we, tv[i].mwe);
      cyc();
    end
    chk("tv_rec_len", rec_len, 5);
    clear_in();
    rec_we = 4'hF; record_btn = 1;
    #1 chk("abort_on_record", play_abort, 1);
    cyc();
    repeat (GAP) begin
      #1 chk("gap_we_after_abort", mem_we, 0);
      cyc();
    end
    #1 chk("rec_start_after_abort", rec_start, 1);
    chk("rec_len_cleared", rec_len, 0);
    record_btn = 0;
    for (int a = 0; a < 1024; a++) begin
      rec_addr = AW'(a); rec_we = 4'hF; rec_wdata = $urandom;
      cyc();
    end
    rec_we = 0; rec_done = 1;
    cyc();
    rec_done = 0;
    #1 chk("full_rec_len", rec_len, 1023);
    chk("full_rec_valid", rec_valid, 1);
    chk("full_idle", busy, 0);
    start_record();
    for (int a = 0; a < 100; a++) begin
      rec_addr = AW'(a); rec_we = 4'hF; rec_wdata = $urandom;
      cyc();
    end
    clear_in(); rec_done = 1;
    cyc();
    clear_in(); play_btn = 1;
    cyc();
    repeat (GAP) cyc();
    #1 chk("play_start_after_gap", play_start, 1);
    play_btn = 0;
    for (int a = 0; a < 100; a++) begin
      play_addr = AW'(a);
      #1 chk("play_abort_at_end", play_abort, a == 99);
      cyc();
    end
    #1 chk("idle_after_play", busy, 0);
    record_btn = 1; play_btn = 1;
    cyc();
    repeat (GAP) cyc();
    #1 chk("simul_edges_record", rec_start, 1);
    clear_in();
    cyc();
    play_btn = 1; rec_we = 4'h5; rec_addr = 7;
    #1 chk("play_in_record_we", mem_we, 4'h5);
    cyc();
    #1 chk("play_in_record_no_start", play_start, 0);
    clear_in(); rec_done = 1;
    cyc();
    clear_in();
    cyc();
    start_record();
    for (int a = 0; a <= 500; a++) begin
      rec_addr = AW'(a); rec_we = 4'hF; rec_wdata = 32'hA5A5_0000 | a;
      if (a < 500) cyc();
    end
    reset = 0;
    mreset();
    #1 chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rec_valid", rec_valid, 0);
    clear_in();
    cyc();
    cyc();
    reset = 1;
    repeat (4) cyc();
    chk("post_rst_rec_valid", rec_valid, 0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) record_btn = ~record_btn;
      if ($urandom_range(0, 14) == 0) play_btn = ~play_btn;
      rec_done = $urandom_range(0, 59) == 0;
      rec_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      rec_addr = AW'($urandom);
      rec_wdata = $urandom;
      play_addr = $urandom_range(0, 2) == 0 ? AW'(m_len) : AW'($urandom);
      reset = $urandom_range(0, 999) != 0;
      if (!reset) mreset();
      cyc();
      reset = 1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
